mem_line_ctrl: RTL and testbench

//  Parametrised, synthesisable main-memory controller on bus2, sitting between the cache and backing RAM.

---
 rtl/mem_line_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_line_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_ctrl.sv
// -----------------------------------------------------------------------------
// mem_line_ctrl
//   Main-memory line controller on bus2, between the cache and backing RAM.
//   Stores 2**ADDR_W lines of LINE_BYTES bytes. A WRITE_LINE transfers a line
//   in BEATS = LINE_BYTES/BUS_BYTES beats starting at the command edge and is
//   acknowledged with a single RESPONSE cycle. A READ_LINE returns the line as
//   BEATS consecutive RESPONSE cycles. The first response is sampled by the
//   cache DELAY edges after the command edge. Bus2 is split into in/out/oe
//   wires; tristate merging happens above this block.
//
// Ports
//   CLK     in   clock, all logic on posedge
//   RESET   in   synchronous active-low reset
//   C2_IN   in   [1:0]        command: NOP=0, RESPONSE=1, READ_LINE=2, WRITE_LINE=3
//   A2_IN   in   [ADDR_W-1:0] line address, sampled with the command
//   D2_IN   in   [8*BUS_BYTES-1:0] write-data beat (little-endian within line)
//   C2_OUT  out  [1:0]        response code (RESPONSE while driving, else NOP)
//   C2_OE   out  controller drives C2
//   D2_OUT  out  [8*BUS_BYTES-1:0] read-data beat (0 when not driving)
//   D2_OE   out  controller drives D2
//   BUSY    out  high from command accept through the last response edge
// -----------------------------------------------------------------------------
module mem_line_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int LINE_BYTES = 16,
  parameter int BUS_BYTES  = 2,
  parameter int DELAY      = 100
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [1:0]               C2_IN,
  input  logic [ADDR_W-1:0]        A2_IN,
  input  logic [8*BUS_BYTES-1:0]   D2_IN,
  output logic [1:0]               C2_OUT,
  output logic                     C2_OE,
  output logic [8*BUS_BYTES-1:0]   D2_OUT,
  output logic                     D2_OE,
  output logic                     BUSY
);

  localparam int BUS_W  = 8 * BUS_BYTES;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int BEATS  = LINE_BYTES / BUS_BYTES;
  localparam int DCNT_W = $clog2(DELAY + 1);
  localparam int BCNT_W = $clog2(BEATS + 1);
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_RESP  = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  generate
    if (LINE_BYTES % BUS_BYTES != 0) begin : g_bad_bus
      $error("mem_line_ctrl: LINE_BYTES must be a multiple of BUS_BYTES");
    end
    if (DELAY < BEATS + 1) begin : g_bad_delay
      $error("mem_line_ctrl: DELAY must be at least BEATS+1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    WR_RECV,
    WR_WAIT,
    WR_RESP,
    RD_WAIT,
    RD_SEND
  } state_t;

  function automatic logic [BUS_W-1:0] get_beat(input logic [LINE_W-1:0] line,
                                                input logic [BCNT_W-1:0] idx);
    get_beat = line[int'(idx)*BUS_W +: BUS_W];
  endfunction

  function automatic logic [LINE_W-1:0] put_beat(input logic [LINE_W-1:0] line,
                                                 input logic [BCNT_W-1:0] idx,
                                                 input logic [BUS_W-1:0]  beat);
    put_beat = line;
    put_beat[int'(idx)*BUS_W +: BUS_W] = beat;
  endfunction

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wr_line, wr_line_d;
  logic [LINE_W-1:0]   rd_line;
  logic [BCNT_W-1:0]   beat_cnt, beat_d;
  logic [DCNT_W-1:0]   dly_cnt, dly_d;
  logic [1:0]          c2_out_d;
  logic                c2_oe_d, d2_oe_d, busy_d;
  logic [BUS_W-1:0]    d2_out_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [LINE_W-1:0]   mem_wdata;
  logic                rd_load;

  logic [LINE_W-1:0]   mem [DEPTH];

  // dly_cnt holds the number of edges elapsed since the command edge, so the
  // response register is loaded when it reaches DELAY-1 and the cache sees it
  // at edge T+DELAY. The write-response cycle also accepts a new command,
  // making the response edge the earliest next command edge after a write.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state;
    addr_d    = addr_q;
    wr_line_d = wr_line;
    beat_d    = beat_cnt;
    dly_d     = dly_cnt;
    c2_out_d  = CMD_NOP;
    c2_oe_d   = 1'b0;
    d2_out_d  = '0;
    d2_oe_d   = 1'b0;
    busy_d    = BUSY;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wr_line;
    rd_load   = 1'b0;

    case (state)
      IDLE, WR_RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        beat_d  = '0;
        dly_d   = '0;
        case (C2_IN)
          CMD_WRITE: begin
            addr_d    = A2_IN;
            wr_line_d = put_beat(wr_line, '0, D2_IN);
            beat_d    = BCNT_W'(1);
            dly_d     = DCNT_W'(1);
            busy_d    = 1'b1;
            if (BEATS == 1) begin
              mem_we    = 1'b1;
              mem_waddr = A2_IN;
              mem_wdata = wr_line_d;
              state_d   = WR_WAIT;
            end else begin
              state_d   = WR_RECV;
            end
          end
          CMD_READ: begin
            addr_d  = A2_IN;
            rd_load = 1'b1;
            dly_d   = DCNT_W'(1);
            busy_d  = 1'b1;
            state_d = RD_WAIT;
          end
          default: ;  // NOP, RESPONSE and unknown codes are ignored
        endcase
      end

      WR_RECV: begin
        wr_line_d = put_beat(wr_line, beat_cnt, D2_IN);
        beat_d    = beat_cnt + BCNT_W'(1);
        dly_d     = dly_cnt + DCNT_W'(1);
        // The line is committed only once the final beat is in hand.
        if (beat_cnt == BCNT_W'(BEATS - 1)) begin
          mem_we    = 1'b1;
          mem_wdata = wr_line_d;
          state_d   = WR_WAIT;
        end
      end

      WR_WAIT: begin
        dly_d = dly_cnt + DCNT_W'(1);
        if (dly_cnt == DCNT_W'(DELAY - 1)) begin
          c2_out_d = CMD_RESP;
          c2_oe_d  = 1'b1;
          state_d  = WR_RESP;
        end
      end

      RD_WAIT: begin
        dly_d = dly_cnt + DCNT_W'(1);
        if (dly_cnt == DCNT_W'(DELAY - 1)) begin
          c2_out_d = CMD_RESP;
          c2_oe_d  = 1'b1;
          d2_out_d = get_beat(rd_line, '0);
          d2_oe_d  = 1'b1;
          beat_d   = BCNT_W'(1);
          state_d  = RD_SEND;
        end
      end

      RD_SEND: begin
        if (beat_cnt == BCNT_W'(BEATS)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          c2_out_d = CMD_RESP;
          c2_oe_d  = 1'b1;
          d2_out_d = get_beat(rd_line, beat_cnt);
          d2_oe_d  = 1'b1;
          beat_d   = beat_cnt + BCNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      beat_cnt <= '0;
      dly_cnt  <= '0;
      C2_OUT   <= CMD_NOP;
      C2_OE    <= 1'b0;
      D2_OUT   <= '0;
      D2_OE    <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      beat_cnt <= beat_d;
      dly_cnt  <= dly_d;
      C2_OUT   <= c2_out_d;
      C2_OE    <= c2_oe_d;
      D2_OUT   <= d2_out_d;
      D2_OE    <= d2_oe_d;
      BUSY     <= busy_d;
    end
  end

  // Datapath registers carry no control meaning, so they are left unreset.
  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    wr_line <= wr_line_d;
    if (rd_load) begin
      rd_line <= mem[A2_IN];
    end
  end

  // NOTE: the line array is never reset (it maps onto RAM); only the write
  // enable is gated by reset, so an aborted receive leaves the line intact.
  always_ff @(posedge CLK) begin
    if (RESET && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_line_ctrl
//   Self-checking bench for mem_line_ctrl. A default-parameter instance is
//   exercised with line writes/reads, busy-time command noise, resets during
//   and after the write receive, and address-range extremes. A second instance
//   (4-byte line, 4-byte bus, DELAY=3) covers back-to-back write/read.
//   Expected values come from an associative-array line memory and from the
//   edge arithmetic of the bus protocol.
// -----------------------------------------------------------------------------
module tb_mem_line_ctrl;

  localparam int ADDR_W     = 10;
  localparam int LINE_BYTES = 16;
  localparam int BUS_BYTES  = 2;
  localparam int DELAY      = 100;
  localparam int BUS_W      = 8 * BUS_BYTES;
  localparam int LINE_W     = 8 * LINE_BYTES;
  localparam int BEATS      = LINE_BYTES / BUS_BYTES;

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_RESP  = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  logic              CLK;
  logic              RESET;
  logic [1:0]        C2_IN;
  logic [ADDR_W-1:0] A2_IN;
  logic [BUS_W-1:0]  D2_IN;
  logic [1:0]        C2_OUT;
  logic              C2_OE;
  logic [BUS_W-1:0]  D2_OUT;
  logic              D2_OE;
  logic              BUSY;

  logic [1:0]        c6_in;
  logic [ADDR_W-1:0] a6_in;
  logic [31:0]       d6_in;
  logic [1:0]        c6_out;
  logic              c6_oe;
  logic [31:0]       d6_out;
  logic              d6_oe;
  logic              busy6;

  mem_line_ctrl #(
    .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .BUS_BYTES(BUS_BYTES), .DELAY(DELAY)
  ) dut (
    .CLK(CLK), .RESET(RESET), .C2_IN(C2_IN), .A2_IN(A2_IN), .D2_IN(D2_IN),
    .C2_OUT(C2_OUT), .C2_OE(C2_OE), .D2_OUT(D2_OUT), .D2_OE(D2_OE), .BUSY(BUSY)
  );

  mem_line_ctrl #(
    .ADDR_W(ADDR_W), .LINE_BYTES(4), .BUS_BYTES(4), .DELAY(3)
  ) dut6 (
    .CLK(CLK), .RESET(RESET), .C2_IN(c6_in), .A2_IN(a6_in), .D2_IN(d6_in),
    .C2_OUT(c6_out), .C2_OE(c6_oe), .D2_OUT(d6_out), .D2_OE(d6_oe), .BUSY(busy6)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [LINE_W-1:0] ref_mem [int];
  int written[$];

  // Advance past the next rising edge; outputs seen afterwards are the values
  // the cache samples at edge cyc+1, and inputs set now are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                          input string tag);
    int t;
    int n_resp, resp_edge, code_bad, d2oe_seen, busy_low;
    t = cyc + 1;
    n_resp = 0; resp_edge = -1; code_bad = 0; d2oe_seen = 0; busy_low = 0;
    C2_IN = CMD_WRITE; A2_IN = addr; D2_IN = line[0 +: BUS_W];
    tick();
    for (int e = t + 1; e <= t + DELAY; e++) begin
      if (C2_OE === 1'b1) begin
        n_resp++;
        resp_edge = e;
        if (C2_OUT !== CMD_RESP) code_bad++;
      end
      if (D2_OE !== 1'b0) d2oe_seen++;
      if (BUSY !== 1'b1) busy_low++;
      if (e - t < BEATS) D2_IN = line[(e - t)*BUS_W +: BUS_W];
      else               D2_IN = BUS_W'($urandom);
      if (e == t + DELAY)     C2_IN = CMD_NOP;
      else if (e == t + 40)   C2_IN = CMD_READ;
      else                    C2_IN = 2'($urandom);
      A2_IN = ADDR_W'($urandom);
      tick();
    end
    n_checks++;
    if (n_resp !== 1) begin
      n_fail++; $display("FAIL %s wr_resp_count: got %0d expected 1", tag, n_resp);
    end
    n_checks++;
    if (resp_edge !== t + DELAY) begin
      n_fail++; $display("FAIL %s wr_resp_edge: got T+%0d expected T+%0d", tag, resp_edge - t, DELAY);
    end
    n_checks++;
    if (code_bad !== 0) begin
      n_fail++; $display("FAIL %s wr_resp_code: got %0d bad cycles expected 0", tag, code_bad);
    end
    n_checks++;
    if (d2oe_seen !== 0) begin
      n_fail++; $display("FAIL %s wr_d2_oe: got %0d high cycles expected 0", tag, d2oe_seen);
    end
    n_checks++;
    if (busy_low !== 0) begin
      n_fail++; $display("FAIL %s wr_busy: got %0d low cycles expected 0", tag, busy_low);
    end
    n_checks++;
    if ({BUSY, C2_OE, D2_OE} !== 3'b000) begin
      n_fail++; $display("FAIL %s wr_after: got busy/c2oe/d2oe=%b expected 000", tag, {BUSY, C2_OE, D2_OE});
    end
    ref_mem[int'(addr)] = line;
    written.push_back(int'(addr));
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input string tag);
    int t;
    int c2oe_cnt, oe_bad, data_bad, busy_bad, bad_beat;
    logic [LINE_W-1:0] exp_line;
    logic [BUS_W-1:0]  bad_got, bad_exp;
    exp_line = ref_mem[int'(addr)];
    t = cyc + 1;
    c2oe_cnt = 0; oe_bad = 0; data_bad = 0; busy_bad = 0; bad_beat = -1;
    bad_got = '0; bad_exp = '0;
    C2_IN = CMD_READ; A2_IN = addr; D2_IN = BUS_W'($urandom);
    tick();
    for (int e = t + 1; e <= t + DELAY + BEATS; e++) begin
      if (C2_OE === 1'b1) c2oe_cnt++;
      if (e >= t + DELAY && e < t + DELAY + BEATS) begin
        if (C2_OE !== 1'b1 || D2_OE !== 1'b1 || C2_OUT !== CMD_RESP) oe_bad++;
        if (D2_OUT !== exp_line[(e - t - DELAY)*BUS_W +: BUS_W]) begin
          if (data_bad == 0) begin
            bad_beat = e - t - DELAY;
            bad_got  = D2_OUT;
            bad_exp  = exp_line[(e - t - DELAY)*BUS_W +: BUS_W];
          end
          data_bad++;
        end
      end else if (C2_OE !== 1'b0 || D2_OE !== 1'b0) begin
        oe_bad++;
      end
      if (BUSY !== ((e < t + DELAY + BEATS) ? 1'b1 : 1'b0)) busy_bad++;
      C2_IN = (e == t + DELAY + BEATS) ? CMD_NOP : 2'($urandom);
      A2_IN = ADDR_W'($urandom);
      D2_IN = BUS_W'($urandom);
      tick();
    end
    n_checks++;
    if (c2oe_cnt !== BEATS) begin
      n_fail++; $display("FAIL %s rd_c2oe_cycles: got %0d expected %0d", tag, c2oe_cnt, BEATS);
    end
    n_checks++;
    if (oe_bad !== 0) begin
      n_fail++; $display("FAIL %s rd_oe_timing: got %0d bad cycles expected 0", tag, oe_bad);
    end
    n_checks++;
    if (data_bad !== 0) begin
      n_fail++;
      $display("FAIL %s rd_data: beat %0d got %h expected %h (%0d bad beats)",
               tag, bad_beat, bad_got, bad_exp, data_bad);
    end
    n_checks++;
    if (busy_bad !== 0) begin
      n_fail++; $display("FAIL %s rd_busy: got %0d bad cycles expected 0", tag, busy_bad);
    end
  endtask

  // Quiet cycles between transactions with non-commands on C2.
  task automatic idle(input int n, input string tag);
    int bad;
    logic [1:0] pick;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      pick = 2'($urandom_range(0, 2));
      if (pick == 2'd0)      C2_IN = CMD_NOP;
      else if (pick == 2'd1) C2_IN = CMD_RESP;
      else                   C2_IN = 2'bxx;
      A2_IN = ADDR_W'($urandom);
      D2_IN = BUS_W'($urandom);
      tick();
      if ({BUSY, C2_OE, D2_OE} !== 3'b000) bad++;
    end
    C2_IN = CMD_NOP;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL %s idle_quiet: got %0d active cycles expected 0", tag, bad);
    end
  endtask

  // Start a write and assert reset at edge T+off.
  task automatic aborted_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                               input int off, input string tag);
    int t, resp_seen;
    t = cyc + 1;
    resp_seen = 0;
    C2_IN = CMD_WRITE; A2_IN = addr; D2_IN = line[0 +: BUS_W];
    tick();
    for (int e = t + 1; e <= t + off; e++) begin
      if (C2_OE !== 1'b0) resp_seen++;
      if (e - t < BEATS) D2_IN = line[(e - t)*BUS_W +: BUS_W];
      else               D2_IN = BUS_W'($urandom);
      C2_IN = (e == t + off) ? CMD_NOP : 2'($urandom);
      if (e == t + off) RESET = 1'b0;
      tick();
    end
    n_checks++;
    if ({BUSY, C2_OE, D2_OE} !== 3'b000) begin
      n_fail++; $display("FAIL %s abort_outputs: got busy/c2oe/d2oe=%b expected 000", tag, {BUSY, C2_OE, D2_OE});
    end
    RESET = 1'b1;
    C2_IN = CMD_NOP;
    for (int i = 0; i < DELAY + 10; i++) begin
      tick();
      if ({BUSY, C2_OE, D2_OE} !== 3'b000) resp_seen++;
    end
    n_checks++;
    if (resp_seen !== 0) begin
      n_fail++; $display("FAIL %s abort_no_response: got %0d active cycles expected 0", tag, resp_seen);
    end
    // The line reaches memory at edge T+BEATS-1 unless reset hits at or before it.
    if (off >= BEATS) begin
      ref_mem[int'(addr)] = line;
      written.push_back(int'(addr));
    end
  endtask

  task automatic test_reset();
    logic [LINE_W-1:0] pat;
    RESET = 1'b0;
    C2_IN = CMD_WRITE; A2_IN = 10'h0AA; D2_IN = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({C2_OUT, C2_OE, D2_OE, BUSY, D2_OUT} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs edge%0d: got c2out=%0d c2oe=%b d2oe=%b busy=%b d2out=%h expected all 0",
                 i, C2_OUT, C2_OE, D2_OE, BUSY, D2_OUT);
      end
    end
    RESET = 1'b1;
    C2_IN = CMD_NOP;
    idle(2, "reset_release");
    pat = rand_line();
    do_write(10'h0AA, pat, "reset_prep");
    RESET = 1'b0;
    C2_IN = CMD_WRITE; A2_IN = 10'h0AA; D2_IN = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({C2_OUT, C2_OE, D2_OE, BUSY} !== '0) begin
        n_fail++;
        $display("FAIL reset_again edge%0d: got c2out=%0d c2oe=%b d2oe=%b busy=%b expected all 0",
                 i, C2_OUT, C2_OE, D2_OE, BUSY);
      end
    end
    RESET = 1'b1;
    C2_IN = CMD_NOP;
    idle(3, "reset_no_accept");
    do_read(10'h0AA, "reset_no_write");
  endtask

  task automatic test_write_read();
    logic [LINE_W-1:0] line;
    for (int k = 0; k < BEATS; k++) line[k*BUS_W +: BUS_W] = {8'(2*k + 1), 8'(2*k)};
    do_write(10'h155, line, "wr_155");
    do_read(10'h155, "rd_155");
  endtask

  task automatic test_reset_abort();
    do_write(10'h002, '0, "zero_002");
    aborted_write(10'h002, {LINE_W{1'b1}}, 4, "abort_recv_002");
    do_read(10'h002, "rd_002");
    aborted_write(10'h003, rand_line(), 20, "abort_wait_003");
    do_read(10'h003, "rd_003");
  endtask

  task automatic test_boundary();
    do_write(10'h3FF, rand_line(), "wr_3ff");
    do_write(10'h000, rand_line(), "wr_000");
    do_read(10'h3FF, "rd_3ff");
    do_read(10'h000, "rd_000");
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 8; i++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = ADDR_W'($urandom);
        do_write(a, rand_line(), $sformatf("rnd_wr%0d", i));
      end else begin
        a = ADDR_W'(written[$urandom_range(0, written.size() - 1)]);
        do_read(a, $sformatf("rnd_rd%0d", i));
      end
      idle($urandom_range(1, 3), $sformatf("rnd_gap%0d", i));
    end
  endtask

  // Narrow instance: one beat per line, DELAY=3. Write at T answered at T+3,
  // read issued at T+3 answered at T+6.
  task automatic test_back_to_back();
    int t;
    logic [ADDR_W-1:0] a;
    logic [31:0] data;
    logic exp_c, exp_d, exp_b;
    for (int r = 0; r < 2; r++) begin
      a    = (r == 0) ? ADDR_W'(10'h00A) : ADDR_W'($urandom);
      data = (r == 0) ? 32'hDEADBEEF : $urandom;
      t = cyc + 1;
      c6_in = CMD_WRITE; a6_in = a; d6_in = data;
      tick();
      for (int e = t + 1; e <= t + 7; e++) begin
        exp_c = (e == t + 3) || (e == t + 6);
        exp_d = (e == t + 6);
        exp_b = (e <= t + 6);
        n_checks++;
        if ({c6_oe, d6_oe, busy6} !== {exp_c, exp_d, exp_b}) begin
          n_fail++;
          $display("FAIL b2b%0d ctrl T+%0d: got c2oe/d2oe/busy=%b expected %b",
                   r, e - t, {c6_oe, d6_oe, busy6}, {exp_c, exp_d, exp_b});
        end
        if (exp_c) begin
          n_checks++;
          if (c6_out !== CMD_RESP) begin
            n_fail++; $display("FAIL b2b%0d code T+%0d: got %0d expected %0d", r, e - t, c6_out, CMD_RESP);
          end
        end
        if (exp_d) begin
          n_checks++;
          if (d6_out !== data) begin
            n_fail++; $display("FAIL b2b%0d data: got %h expected %h", r, d6_out, data);
          end
        end
        c6_in = (e == t + 3) ? CMD_READ : CMD_NOP;
        a6_in = a;
        d6_in = $urandom;
        tick();
      end
      c6_in = CMD_NOP;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b0;
    C2_IN = CMD_NOP; A2_IN = '0; D2_IN = '0;
    c6_in = CMD_NOP; a6_in = '0; d6_in = '0;
    test_reset();
    test_write_read();
    test_reset_abort();
    test_boundary();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
